bin2pos_strobe: RTL
===================

Name: bin2pos_strobe

Overview:
Sequential binary-to-positional (one-hot) strobe generator, the inverse of the team's one-hot-to-binary encoder. Accepts binary index commands over a valid/ready handshake. For each command, drives a registered one-hot vector for PULSE_LEN cycles, then enforces GAP_LEN idle cycles. Used to fire per-channel enables, select lines or interrupt strobes from a binary channel number.

Parameters:
BIN_WIDTH, 8, width of binary index input
POS_WIDTH, 2**BIN_WIDTH, width of one-hot output; legal range 1..2**BIN_WIDTH
PULSE_LEN, 1, cycles the one-hot output stays asserted per command; must be >=1
GAP_LEN, 0, forced idle cycles after each pulse; must be >=0

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
bin_valid  input  1  command valid
bin_ready  output  1  block can accept command this cycle
bin  input  BIN_WIDTH  binary index of bit to assert
abort  input  1  synchronous cancel of current pulse/gap
pos  output  POS_WIDTH  registered one-hot output; all zeros when idle
pos_valid  output  1  high exactly while pos is nonzero
busy  output  1  high in ACTIVE or GAP
err_out_of_range  output  1  one-cycle pulse: accepted command had bin >= POS_WIDTH, command dropped

Behaviour:
- One clock and synchronous active-high reset, as already decided.
- Reset values: pos=0, pos_valid=0, busy=0, err_out_of_range=0, state=IDLE, counter=0. bin_ready=0 while rst=1.
- States:
  - IDLE: bin_ready=1 unless abort=1.
  - ACTIVE: pos=1<<index, counter counts down from PULSE_LEN-1.
  - GAP: pos=0, counter counts down from GAP_LEN-1.
- Accept = bin_valid & bin_ready, sampled at rising edge N.
- In-range accept (bin < POS_WIDTH):
  - Next cycle (after edge N): pos=1<<bin, pos_valid=1, busy=1. Latency is 1 cycle.
  - pos holds for exactly PULSE_LEN cycles. bin is captured at accept and later changes on bin are ignored.
- ACTIVE exit at counter==0:
  - GAP_LEN>0: go to GAP, pos=0, busy=1 for GAP_LEN cycles, then IDLE.
  - GAP_LEN==0: go to IDLE. bin_ready is also 1 in the last ACTIVE cycle, so a command accepted there produces its one-hot on the very next cycle with no zero cycle between pulses. Sustained throughput is one command per PULSE_LEN+GAP_LEN cycles.
- Out-of-range accept (bin >= POS_WIDTH; possible only when POS_WIDTH < 2**BIN_WIDTH):
  - Handshake completes and the command is dropped.
  - err_out_of_range=1 for one cycle after edge N. pos stays 0 and state is unchanged (IDLE, or IDLE after a back-to-back last ACTIVE cycle).
- abort=1 at an edge:
  - Next cycle: pos=0, pos_valid=0, busy=0, state IDLE, counter cleared.
  - bin_ready is forced 0 while abort=1, so no command is accepted in that cycle. abort has priority over accept and counter expiry.
- rst has priority over abort and everything else. Reset mid-pulse clears pos on the next edge; no partial pulse resumes.
- bin_valid without bin_ready: command is not consumed. The source must hold bin stable until accepted; the block places no other requirement on bin_valid.
- Invariants:
  - pos is zero or exactly one-hot.
  - pos_valid == (pos != 0).
  - busy=0 implies pos=0.
- Counter width is enough to hold max(PULSE_LEN, GAP_LEN) - 1; no wrap-around is possible.

Test Plan:
1. Defaults (BIN_WIDTH=8, PULSE_LEN=1, GAP_LEN=0). Send bin=5 at edge 10 -> pos=256'h20 and pos_valid=1 for cycle 11 only; pos=0 at cycle 12.
2. PULSE_LEN=3, GAP_LEN=2, POS_WIDTH=16, BIN_WIDTH=4. Send bin=15, hold bin_valid with bin=2 -> pos=16'h8000 for 3 cycles, 2 zero cycles with bin_ready=0, then pos=16'h0004 starting the cycle after the re-accept.
3. GAP_LEN=0, PULSE_LEN=2. Stream bin=0,1,2 continuously -> pos=1,1,2,2,4,4 with no zero cycles; bin_ready high every 2nd cycle.
4. POS_WIDTH=10, BIN_WIDTH=4. Send bin=12 -> handshake completes, err_out_of_range=1 for one cycle, pos stays 0, next bin=9 gives pos=10'h200.
5. PULSE_LEN=8. Assert abort in the 3rd pulse cycle while bin_valid=1 -> pos=0 and busy=0 next cycle, no accept during the abort cycle, command accepted on the following cycle.
6. PULSE_LEN=4. Assert rst mid-pulse -> all outputs 0 on the next edge, bin_ready=0 during rst and =1 the first cycle after rst drops.

Source files
------------

// File: rtl/bin2pos_strobe.sv
// Sequential binary-to-one-hot strobe generator: each accepted index fires a
// registered one-hot pulse of PULSE_LEN cycles followed by GAP_LEN idle cycles.
module bin2pos_strobe #(
    parameter int BIN_WIDTH = 8,
    parameter int POS_WIDTH = 2**BIN_WIDTH,
    parameter int PULSE_LEN = 1,
    parameter int GAP_LEN   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bin_valid,
    output logic                 bin_ready,
    input  logic [BIN_WIDTH-1:0] bin,
    input  logic                 abort,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 pos_valid,
    output logic                 busy,
    output logic                 err_out_of_range
);

    localparam int CNT_MAX = ((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0]     PULSE_INIT = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0]     GAP_INIT   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [POS_WIDTH-1:0] POS_ONE    = POS_WIDTH'(1);
    localparam logic [BIN_WIDTH:0]   POS_LIMIT  = (BIN_WIDTH + 1)'(POS_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [POS_WIDTH-1:0]   pos_q, pos_d;
    logic                   pos_valid_q, pos_valid_d;
    logic                   err_q, err_d;
    logic                   last_active;
    logic                   accept;
    logic                   in_range;

    // With no gap, the final pulse cycle doubles as an accept slot so pulses abut.
    assign last_active = (state_q == S_ACTIVE) && (cnt_q == '0);
    assign bin_ready   = !rst && !abort &&
                         ((state_q == S_IDLE) || ((GAP_LEN == 0) && last_active));
    assign accept      = bin_valid && bin_ready;
    assign in_range    = ({1'b0, bin} < POS_LIMIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        err_d   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pos_d   = '0;
        end else begin
            if (state_q == S_ACTIVE) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (GAP_LEN > 0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_INIT;
                    pos_d   = '0;
                end else begin
                    state_d = S_IDLE;
                    pos_d   = '0;
                end
            end else if (state_q == S_GAP) begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = S_IDLE;
            end
            // Accept overrides the expiry decision above (back-to-back case).
            if (accept) begin
                if (in_range) begin
                    state_d = S_ACTIVE;
                    cnt_d   = PULSE_INIT;
                    pos_d   = POS_ONE << bin;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        pos_valid_d = |pos_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            err_q       <= err_d;
        end
    end

    assign pos              = pos_q;
    assign pos_valid        = pos_valid_q;
    assign busy             = (state_q != S_IDLE);
    assign err_out_of_range = err_q;

endmodule
